// File: rtl/nn_infer_sequencer.sv
// Sequencer for the shared MAC datapath of the MNIST accelerator: buffers one
// binarised image, walks every class through clear/accumulate/compare and keeps a running argmax.
module nn_infer_sequencer #(
    parameter int unsigned N_IN    = 64,
    parameter int unsigned N_OUT   = 10,
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned MAC_LAT = 1,
    localparam int unsigned AW     = $clog2(N_IN * N_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic [AW-1:0]    w_addr,
    output logic             pix_bit,
    output logic             mac_clr,
    output logic             mac_en,
    input  logic [ACC_W-1:0] mac_acc,
    output logic [3:0]       digit,
    output logic             done,
    output logic             busy
);

    localparam int unsigned NB = N_IN / 8;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned IW = $clog2(N_IN);
    localparam int unsigned OW = $clog2(N_OUT);
    localparam int unsigned LW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [BW-1:0]            beat;
    logic [IW-1:0]            i;
    logic [OW-1:0]            o;
    logic [LW-1:0]            lat_cnt;
    logic [N_IN-1:0]          pix_buf;
    logic signed [ACC_W-1:0]  best;
    logic [OW-1:0]            best_idx;
    logic [AW-1:0]            run_addr;
    logic                     last_beat;
    logic                     last_pix;
    logic                     last_class;
    logic                     better;

    assign run_addr   = AW'(o) * AW'(N_IN) + AW'(i);
    assign last_beat  = (beat == BW'(NB - 1));
    assign last_pix   = (i == IW'(N_IN - 1));
    assign last_class = (o == OW'(N_OUT - 1));
    // Class 0 always seeds the running best; later classes must be strictly greater so ties keep the lower index.
    assign better     = (o == '0) || ($signed(mac_acc) > best);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        w_addr    = '0;
        pix_bit   = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) state_nxt = S_CLR;
            end
            S_CLR: begin
                mac_clr   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                mac_en  = 1'b1;
                w_addr  = run_addr;
                pix_bit = pix_buf[i];
                if (last_pix) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == LW'(MAC_LAT - 1)) state_nxt = S_CMP;
            end
            S_CMP: begin
                state_nxt = last_class ? S_DONE : S_CLR;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pixel buffer, loop counters and argmax tracking advance with the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat     <= '0;
            i        <= '0;
            o        <= '0;
            lat_cnt  <= '0;
            pix_buf  <= '0;
            best     <= '0;
            best_idx <= '0;
            digit    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) beat <= '0;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        pix_buf[{beat, 3'b000} +: 8] <= in_data;
                        beat                         <= beat + 1'b1;
                        if (last_beat) o <= '0;
                    end
                end
                S_CLR: begin
                    i <= '0;
                end
                S_RUN: begin
                    i       <= i + 1'b1;
                    lat_cnt <= '0;
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
                S_CMP: begin
                    if (better) begin
                        best     <= $signed(mac_acc);
                        best_idx <= o;
                    end
                    if (!last_class) o <= o + 1'b1;
                end
                S_DONE: begin
                    digit <= 4'(best_idx);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Scoreboard bench for nn_infer_sequencer: a default instance and an N_IN=16 / MAC_LAT=3 instance,
// each driven by a bench MAC model that returns per-class scores only once the latency has elapsed.
module tb_nn_infer_sequencer;

    typedef struct {
        int inst;
        int digit;
        int lat;
    } exp_t;

    typedef int score_t [10];

    logic        clk;
    logic        rst_n;
    logic        start_v    [2];
    logic        in_valid_v [2];
    logic [7:0]  in_data_v  [2];
    logic        in_ready_v [2];
    logic        pix_bit_v  [2];
    logic        mac_clr_v  [2];
    logic        mac_en_v   [2];
    logic [15:0] mac_acc_v  [2];
    logic [3:0]  digit_v    [2];
    logic        done_v     [2];
    logic        busy_v     [2];
    logic [9:0]  w_addr_a;
    logic [7:0]  w_addr_b;

    exp_t        exp_q [$];
    int          score [2][10];
    logic [63:0] img [2];
    bit          finished = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    int beats [2];
    int ea [2];
    int clrs [2];
    int gap [2];
    int acc_edge [2];
    int last_digit [2];
    bit prev_clr [2];

    int m_cls [2];
    int m_en [2];
    int m_post [2];

    nn_infer_sequencer u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_v[0]),
        .in_valid (in_valid_v[0]),
        .in_data  (in_data_v[0]),
        .in_ready (in_ready_v[0]),
        .w_addr   (w_addr_a),
        .pix_bit  (pix_bit_v[0]),
        .mac_clr  (mac_clr_v[0]),
        .mac_en   (mac_en_v[0]),
        .mac_acc  (mac_acc_v[0]),
        .digit    (digit_v[0]),
        .done     (done_v[0]),
        .busy     (busy_v[0])
    );

    nn_infer_sequencer #(.N_IN(16), .MAC_LAT(3)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_v[1]),
        .in_valid (in_valid_v[1]),
        .in_data  (in_data_v[1]),
        .in_ready (in_ready_v[1]),
        .w_addr   (w_addr_b),
        .pix_bit  (pix_bit_v[1]),
        .mac_clr  (mac_clr_v[1]),
        .mac_en   (mac_en_v[1]),
        .mac_acc  (mac_acc_v[1]),
        .digit    (digit_v[1]),
        .done     (done_v[1]),
        .busy     (busy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nin(input int k);
        return (k == 0) ? 64 : 16;
    endfunction

    function automatic int mlat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Bench MAC: holds an obviously-winning junk value until MAC_LAT+1 cycles past the last accumulate.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cls[k]  = -1;
                m_en[k]   = 0;
                m_post[k] = 0;
            end else begin
                if (start_v[k] && !busy_v[k]) m_cls[k] = -1;
                if (mac_clr_v[k]) begin
                    m_cls[k]++;
                    m_en[k]   = 0;
                    m_post[k] = 0;
                end
                if (mac_en_v[k]) begin
                    m_en[k]++;
                    m_post[k] = 0;
                end else begin
                    m_post[k]++;
                end
            end
            if (rst_n && m_en[k] == nin(k) && m_post[k] >= mlat(k) + 1 && m_cls[k] >= 0 && m_cls[k] < 10)
                mac_acc_v[k] = 16'(score[k][m_cls[k]]);
            else
                mac_acc_v[k] = 16'h7FFF;
        end
    end

    task automatic chk(input int k, input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d", nm, k, cyc, act, req);
        end
    endtask

    task automatic mon(input int k, input bit rdy, input bit clr, input bit en, input int wa,
                       input bit pb, input int dg, input bit dn, input bit bz, input bit vld, input bit st);
        int   ni;
        exp_t e;
        ni = nin(k);
        if (!rst_n) begin
            chk(k, "reset_outputs_zero", int'(rdy) + int'(clr) + int'(en) + int'(dn) + int'(bz) + int'(pb) + wa + dg, 0);
            beats[k] = 0; ea[k] = 0; clrs[k] = 0; gap[k] = 0; last_digit[k] = 0; prev_clr[k] = 1'b0;
            return;
        end
        if (!dn) chk(k, "digit_hold", dg, last_digit[k]);
        if (st && !bz) begin
            beats[k] = 0; ea[k] = 0; clrs[k] = 0; gap[k] = 0;
        end
        if (rdy) begin
            chk(k, "in_ready_only_in_load", int'(beats[k] < ni / 8 && bz && !en && !clr), 1);
            if (vld) begin
                beats[k]++;
                if (beats[k] == ni / 8) acc_edge[k] = cyc + 1;
            end
        end
        if (clr) begin
            clrs[k]++;
            if (ea[k] > 0) chk(k, "wait_cmp_gap", gap[k], mlat(k) + 1);
        end
        if (en) begin
            chk(k, "w_addr", wa, ea[k]);
            chk(k, "pix_bit", int'(pb), int'(img[k][ea[k] % ni]));
            if (ea[k] % ni == 0) chk(k, "clr_before_run", int'(prev_clr[k]), 1);
            ea[k]++;
            gap[k] = 0;
        end else if (!clr && !dn && bz && ea[k] > 0) begin
            gap[k]++;
        end
        if (dn) begin
            if (exp_q.size() == 0) begin
                chk(k, "unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk(k, "done_instance", k, e.inst);
                chk(k, "done_latency", cyc + 1 - acc_edge[k], e.lat);
                chk(k, "beats_accepted", beats[k], ni / 8);
                chk(k, "mac_en_count", ea[k], 10 * ni);
                chk(k, "mac_clr_count", clrs[k], 10);
                chk(k, "final_wait_gap", gap[k], mlat(k) + 1);
                last_digit[k] = e.digit;
            end
        end
        prev_clr[k] = clr;
    endtask

    // Monitor: checks both instances every cycle and owns the summary.
    always @(negedge clk) begin
        mon(0, in_ready_v[0], mac_clr_v[0], mac_en_v[0], int'(w_addr_a), pix_bit_v[0], int'(digit_v[0]),
            done_v[0], busy_v[0], in_valid_v[0], start_v[0]);
        mon(1, in_ready_v[1], mac_clr_v[1], mac_en_v[1], int'(w_addr_b), pix_bit_v[1], int'(digit_v[1]),
            done_v[1], busy_v[1], in_valid_v[1], start_v[1]);
        if (finished) begin
            chk(0, "scoreboard_drained", exp_q.size(), 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_scores(input int k, input score_t s);
        for (int c = 0; c < 10; c++) score[k][c] = s[c];
    endtask

    task automatic begin_inf(input int k, input logic [63:0] image, input bit toggle,
                             input bit push, input int dig, input int lat);
        exp_t e;
        int   n;
        img[k] = image;
        if (push) begin
            e.inst = k; e.digit = dig; e.lat = lat;
            exp_q.push_back(e);
        end
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        for (int b = 0; b < nin(k) / 8; b++) begin
            in_data_v[k]  = image[8*b +: 8];
            in_valid_v[k] = 1'b1;
            n = 0;
            while (!in_ready_v[k] && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) $display("FAIL load_timeout inst%0d beat %0d", k, b);
            tick();
            in_valid_v[k] = 1'b0;
            if (toggle) tick();
        end
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!done_v[k] && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) $display("FAIL done_timeout inst%0d", k);
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b0; in_valid_v[k] = 1'b0; in_data_v[k] = 8'h00; img[k] = '0;
        end
        set_scores(0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        set_scores(1, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Address sweep with toggling in_valid; argmax tie between classes 2 and 3.
        set_scores(0, '{-5, 3, 7, 7, -100, 0, 2, 6, 1, -1});
        begin_inf(0, 64'h0807_0605_0403_0201, 1'b1, 1'b1, 2, 671);
        wait_done(0);

        // All-negative scores with start pulsed during RUN and during WAIT.
        set_scores(0, '{-9, -8, -3, -4, -10, -11, -12, -20, -30, -5});
        begin_inf(0, 64'hA5A5_5A5A_F00F_C33C, 1'b0, 1'b1, 2, 671);
        n = 0;
        while (!mac_en_v[0] && n < 50) begin tick(); n++; end
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        n = 0;
        while (mac_en_v[0] && n < 200) begin tick(); n++; end
        start_v[0] = 1'b1; tick(); start_v[0] = 1'b0;
        wait_done(0);

        // Class 0 uniquely maximal.
        set_scores(0, '{50, 49, -50, 49, 0, 1, 2, 3, 4, 5});
        begin_inf(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, 671);
        wait_done(0);

        // Reset in the middle of class 3, pixel 20: the run is abandoned without a done pulse.
        set_scores(0, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        begin_inf(0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 0, 0);
        n = 0;
        while (!(mac_en_v[0] && w_addr_a == 10'd212) && n < 1000) begin tick(); n++; end
        if (n >= 1000) $display("FAIL reset_point_timeout inst0");
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Full inference after the abort; tie at 12 between classes 7 and 9.
        set_scores(0, '{0, 0, 0, 0, 0, 0, 0, 12, 11, 12});
        begin_inf(0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 7, 671);
        wait_done(0);

        // Short image, three-cycle MAC latency.
        set_scores(1, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        begin_inf(1, 64'h0000_0000_0000_BEEF, 1'b1, 1'b1, 9, 211);
        wait_done(1);

        // Signed extremes on the short configuration.
        set_scores(1, '{-32768, -1, 32766, 5, -32768, 32765, 0, 0, 0, 0});
        begin_inf(1, 64'h0000_0000_0000_1234, 1'b0, 1'b1, 2, 211);
        wait_done(1);

        repeat (3) tick();
        finished = 1'b1;
        repeat (5) tick();
    end

endmodule

// File: doc/nn_infer_sequencer.md
Name: nn_infer_sequencer

Overview:
- Controller that sequences the shared MAC datapath of the MNIST accelerator for one inference.
- Buffers a binarised image streamed in over the 8-bit input pins, then walks every output class: clear MAC, issue one MAC step per pixel with matching weight address, and collect the class score.
- Tracks a running argmax and presents the winning class as a 4-bit digit to the seven-segment driver and the uio pins.
- The MAC unit and weight ROM are external; this block owns only sequencing, addressing and argmax.

Parameters:
- N_IN, 64, pixels per image; must be a multiple of 8 and at least 8.
- N_OUT, 10, output classes; 2..16.
- ACC_W, 16, signed MAC accumulator width.
- MAC_LAT, 1, cycles from the last mac_en edge until mac_acc is valid; must be at least 1.
- Derived localparam: AW = clog2(N_IN*N_OUT), the weight address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a new inference; sampled only in IDLE.
- in_valid  in  1  pixel byte valid.
- in_data  in  8  8 binary pixels; bit b is pixel 8*beat+b.
- in_ready  out  1  high only in LOAD.
- w_addr  out  AW  weight ROM address, o*N_IN+i.
- pix_bit  out  1  pixel i fed to the MAC with the current weight.
- mac_clr  out  1  clear the MAC accumulator.
- mac_en  out  1  MAC accumulates this cycle.
- mac_acc  in  ACC_W  signed MAC accumulator value.
- digit  out  4  argmax class of the last completed inference.
- done  out  1  one-cycle pulse when digit updates.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - digit, done, busy, in_ready, mac_clr and mac_en all go to 0.
  - w_addr and pix_bit go to 0.
  - Pixel buffer, counters, best score and best index are cleared.
  - Reset mid-inference abandons the run with no done pulse.
- IDLE:
  - start=1 moves to LOAD and clears beat to 0.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - On each cycle with in_valid=1, in_data is stored at buffer bits [8*beat+7 : 8*beat] and beat increments.
  - After the edge that accepts beat N_IN/8-1, move to CLR with o=0.
  - in_valid=0 stalls LOAD indefinitely.
- CLR:
  - mac_clr=1 for exactly one cycle, i reset to 0, then move to RUN.
- RUN:
  - mac_en=1, w_addr=o*N_IN+i, pix_bit=buffer[i], all combinational from the registered o and i.
  - Lasts exactly N_IN consecutive cycles, i = 0..N_IN-1, then moves to WAIT.
- WAIT:
  - mac_en=0; lasts MAC_LAT cycles, then moves to CMP.
- CMP:
  - mac_acc is sampled as a signed value.
  - If o==0 or mac_acc > best (strict, signed), then best<=mac_acc and best_idx<=o.
  - Ties keep the lower class index.
  - If o==N_OUT-1, move to DONE; otherwise o++ and move to CLR.
- DONE:
  - digit<=final best_idx and done=1 for this single cycle, then move to IDLE.
  - digit holds its value until the next DONE or reset.
- Latency:
  - done is high exactly N_OUT*(N_IN+2+MAC_LAT)+1 cycles after the edge accepting the final beat.
  - With defaults that is 671 cycles.
- Outputs outside their active states are 0: mac_clr, mac_en, in_ready, done, and w_addr/pix_bit outside RUN.
- No arithmetic is performed on weights here; only the signed compare on ACC_W bits.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-RUN, class 3, i=20; release it.
  - Required: all outputs 0, busy=0, no done pulse.
  - Then start plus 8 beats: a full inference completes normally.
- Address and handshake sweep:
  - Stimulus: defaults, image bytes 0x01..0x08, in_valid toggling 1/0.
  - Required: exactly 8 beats accepted, in_ready high only in LOAD.
  - Required: mac_en pulses 640 times with w_addr 0..639 in order.
  - Required: pix_bit matches the buffer bit; mac_clr pulses 10 times, each one cycle before its class RUN.
- Argmax with a bench MAC model:
  - Stimulus: bench MAC returns scores {-5,3,7,7,-100,0,2,6,1,-1}.
  - Required: digit=2 (tie with class 3 keeps the lower index).
  - Required: done is a single pulse at cycle 671 after the final beat.
- Negative scores:
  - Stimulus: all scores negative, {-9,-8,-3,-4,...}.
  - Required: digit=2, confirming a signed compare.
  - Stimulus: class 0 uniquely maximal.
  - Required: digit=0.
- Start while busy and holding:
  - Stimulus: pulse start during RUN and during WAIT.
  - Required: no restart and no change to the sequence.
  - Required: digit holds its previous result until the new DONE.
- Latency parameter:
  - Stimulus: MAC_LAT=3 and N_IN=16.
  - Required: WAIT lasts 3 cycles; done arrives 10*(16+2+3)+1=211 cycles after the final beat.
